cpc_bus_cycle_monitor: RTL
==========================

# cpc_bus_cycle_monitor

Front-end bus stage for the CPC RAM expansion CPLD. Samples the raw Z80 control strobes on `clk` and classifies each bus cycle. Produces early and extended memory-write qualifiers and a T-state count for the RAM bank mapper downstream. Also captures bank-select I/O writes (0x7FXX, data 0b11xxxxxx) and hands them over through a valid/ack register.

## Interface
Parameters:
- `TCNT_W`, default 3: width of the T-state counter; saturates at all-ones.
- `WCNT_W`, default 8: width of the wait-state statistics counter (`WAIT_COUNT_EN` only).

Ports:
- `clk`  in  1  CPC 4 MHz clock.
- `reset_b`  in  1  reset, asynchronous, active-low.
- `mreq_b`, `iorq_b`, `rd_b`, `wr_b`, `m1_b`, `rfsh_b`  in  1 each  Z80 strobes, active-low.
- `adr15`  in  1  address bit 15.
- `ready`  in  1  gate-array READY; low means wait state.
- `data`  in  8  Z80 data bus.
- `cyc_state`  out  3  current cycle class.
- `tstate_cnt`  out  TCNT_W  posedges since cycle start.
- `mwr_early`  out  1  combinational memory-write predictor.
- `mwr_cyc`  out  1  registered memory-write cycle flag.
- `mwr_cyc_ext`  out  1  `mwr_cyc` extended by one clock half-period.
- `bank_wr_vld`  out  1  captured bank-select byte pending.
- `bank_wr_data`  out  8  captured byte.
- `bank_wr_ack`  in  1  consumer accepts the pending byte.
- `bank_wr_ovf`  out  1  sticky flag: capture while `bank_wr_vld` was pending.
- `cyc_err`  out  1  sticky flag: illegal strobe combination.
- `wait_cnt`  out  WCNT_W  wait states seen (`WAIT_COUNT_EN` only).

## Operation
- `cyc_state` encoding: IDLE=0, OPF=1, MRD=2, MWR=3, IORD=4, IOWR=5, RFSH=6, INTA=7.
- At each posedge in IDLE, the next state is chosen by the first matching rule:
  - `!mreq_b & !rfsh_b` → RFSH.
  - `!mreq_b & !m1_b` → OPF.
  - `!mreq_b & !rd_b` → MRD.
  - `!mreq_b & rd_b` → MWR.
  - `!iorq_b & !m1_b` → INTA.
  - `!iorq_b & !rd_b` → IORD.
  - `!iorq_b & !wr_b` → IOWR.
  - Otherwise stay in IDLE.
- Any non-IDLE state holds until `mreq_b & iorq_b` is sampled high, then returns to IDLE. No direct non-IDLE to non-IDLE transitions.
- `mreq_b` is registered on both posedge (`mreq_q`) and negedge (`mreq_f_q`).
- `mwr_early = (mreq_q | mreq_f_q) & !mreq_b & rfsh_b & rd_b & m1_b`.
- `mwr_cyc`: set at posedge when `mwr_early`; cleared at posedge when `mreq_b` is high; otherwise holds.
- `mwr_cyc_ext = mwr_cyc | mwr_cyc_neg`, where `mwr_cyc_neg` is `mwr_cyc` registered on negedge.
- `tstate_cnt`: 0 in IDLE; +1 each posedge while non-IDLE; saturates.
- Bank-select capture fires at most once per I/O cycle: the first posedge in IOWR with `!adr15 & data[7:6]==2'b11` loads `bank_wr_data` and sets `bank_wr_vld`.
- `bank_wr_vld` clears on a posedge with `bank_wr_ack`.
- Capture and ack on the same posedge: new data loaded, `bank_wr_vld` stays 1, no overflow.
- Capture while pending with no ack: data overwritten, `bank_wr_ovf` set.
- `cyc_err` sets when `!mreq_b & !iorq_b` is sampled at a posedge.
- `bank_wr_ovf` and `cyc_err` clear only on reset.

## Timing
- Reset values:
  - `cyc_state`=IDLE, `tstate_cnt`=0.
  - `mwr_cyc`=0, `mwr_cyc_ext`=0.
  - `bank_wr_vld`=0, `bank_wr_data`=0x00.
  - `bank_wr_ovf`=0, `cyc_err`=0, `wait_cnt`=0.
  - `mreq_q`=`mreq_f_q`=1.
- `mwr_early` is valid combinationally in the half-cycle after `mreq_b` falls, i.e. before the first posedge of the cycle. `mwr_cyc` follows 1 posedge later.
- `bank_wr_vld` rises 1 posedge after the IOWR state is entered, i.e. at the second posedge of the I/O write.
- Reset asserted mid-cycle: all state clears immediately (asynchronous). After release, the FSM waits for IDLE conditions before classifying a new cycle.

## Configuration
- `WAIT_COUNT_EN` defined: `wait_cnt` +1 on each posedge with `!ready` in a non-IDLE state, saturating at all-ones.
- `WAIT_COUNT_EN` undefined: `wait_cnt` tied to 0; the `ready` input is unused.

## Structure
- Shared package `cpc_bus_pkg`: cycle-state enum constants (IDLE..INTA); bank-select decode constants (`BANKSEL_TAG=2'b11`, port bit `adr15=0`).
- One sub-module, `cpc_bankwr_hold`: the valid/ack holding register with overflow flag.

## Test plan
- Reset mid-MWR with `tstate_cnt`=2 → every output at its reset value immediately; next legal memory read → MRD.
- Memory write (`mreq_b` low, `rd_b` high, `m1_b` and `rfsh_b` high) → `mwr_early`=1 before the first posedge; `mwr_cyc`=1 at posedge 1; `cyc_state`=3; `tstate_cnt` counts 1,2,3; after `mreq_b` rises, `mwr_cyc_ext` stays high half a clock longer than `mwr_cyc`.
- Opcode fetch followed by refresh → states 1, then 0, then 6; `mwr_early` stays 0 throughout.
- OUT to 0x7F00 with data 0xC5, ack 2 clocks later → `bank_wr_vld`=1 with `bank_wr_data`=0xC5 for exactly 2 clocks, then 0; `bank_wr_ovf`=0.
- Two OUTs (0xC1, then 0xC7) with no ack → `bank_wr_data`=0xC7, `bank_wr_ovf`=1. OUT to 0xBC00 or data 0x45 → no capture.
- With `WAIT_COUNT_EN`: 3-posedge `ready` low inside a memory read → `wait_cnt`=3. `mreq_b` and `iorq_b` low together → `cyc_err`=1.

Source files
------------

// File: rtl/cpc_bus_pkg.sv
// Shared definitions for the CPC bus cycle monitor: cycle classes and
// the bank-select I/O decode used by the RAM expansion.
package cpc_bus_pkg;

  typedef enum logic [2:0] {
    CYC_IDLE = 3'd0,
    CYC_OPF  = 3'd1,
    CYC_MRD  = 3'd2,
    CYC_MWR  = 3'd3,
    CYC_IORD = 3'd4,
    CYC_IOWR = 3'd5,
    CYC_RFSH = 3'd6,
    CYC_INTA = 3'd7
  } cyc_state_e;

  localparam logic [1:0] BANKSEL_TAG   = 2'b11;
  localparam logic       BANKSEL_ADR15 = 1'b0;

  // Bank-select writes go to port 0x7Fxx with the top two data bits set.
  function automatic logic is_banksel(input logic a15, input logic [7:0] d);
    return (a15 == BANKSEL_ADR15) && (d[7:6] == BANKSEL_TAG);
  endfunction

endpackage

// File: rtl/cpc_bankwr_hold.sv
// Valid/ack holding register for captured bank-select bytes, with a sticky
// overflow flag for captures that land on an unacknowledged byte.
module cpc_bankwr_hold (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       cap_i,
  input  logic [7:0] cap_data_i,
  input  logic       ack_i,
  output logic       vld_o,
  output logic [7:0] data_o,
  output logic       ovf_o
);

  logic       vld_q, vld_d;
  logic [7:0] data_q, data_d;
  logic       ovf_q, ovf_d;

  // A capture wins over an ack; overflow only when the old byte was never taken.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    ovf_d  = ovf_q;
    if (cap_i) begin
      data_d = cap_data_i;
      vld_d  = 1'b1;
      if (vld_q && !ack_i) ovf_d = 1'b1;
    end else if (ack_i) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      vld_q  <= 1'b0;
      data_q <= 8'h00;
      ovf_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      ovf_q  <= ovf_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/cpc_bus_cycle_monitor.sv
// Z80 bus cycle classifier and memory-write qualifier for the CPC RAM expansion.
// Optional wait-state statistics counter enabled by defining WAIT_COUNT_EN.
module cpc_bus_cycle_monitor
  import cpc_bus_pkg::*;
#(
  parameter int TCNT_W = 3,
  parameter int WCNT_W = 8
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              mreq_b,
  input  logic              iorq_b,
  input  logic              rd_b,
  input  logic              wr_b,
  input  logic              m1_b,
  input  logic              rfsh_b,
  input  logic              adr15,
  input  logic              ready,
  input  logic [7:0]        data,
  output logic [2:0]        cyc_state,
  output logic [TCNT_W-1:0] tstate_cnt,
  output logic              mwr_early,
  output logic              mwr_cyc,
  output logic              mwr_cyc_ext,
  output logic              bank_wr_vld,
  output logic [7:0]        bank_wr_data,
  input  logic              bank_wr_ack,
  output logic              bank_wr_ovf,
  output logic              cyc_err,
  output logic [WCNT_W-1:0] wait_cnt
);

  cyc_state_e        state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              arm_q, arm_d;
  logic              mreq_q, mreq_f_q;
  logic              mwr_cyc_q, mwr_cyc_d, mwr_cyc_neg_q;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              bus_idle, cap;

  assign bus_idle  = mreq_b & iorq_b;
  assign mwr_early = (mreq_q | mreq_f_q) & !mreq_b & rfsh_b & rd_b & m1_b;
  assign cap       = (state_q == CYC_IOWR) && !done_q && is_banksel(adr15, data);

  // Classification only starts once the bus has been seen idle after reset,
  // so a cycle already in flight at reset release is never misclassified.
  always_comb begin
    state_d = state_q;
    if (state_q == CYC_IDLE) begin
      if (arm_q) begin
        if      (!mreq_b && !rfsh_b) state_d = CYC_RFSH;
        else if (!mreq_b && !m1_b)   state_d = CYC_OPF;
        else if (!mreq_b && !rd_b)   state_d = CYC_MRD;
        else if (!mreq_b)            state_d = CYC_MWR;
        else if (!iorq_b && !m1_b)   state_d = CYC_INTA;
        else if (!iorq_b && !rd_b)   state_d = CYC_IORD;
        else if (!iorq_b && !wr_b)   state_d = CYC_IOWR;
      end
    end else if (bus_idle) begin
      state_d = CYC_IDLE;
    end
  end

  always_comb begin
    arm_d     = arm_q | bus_idle;
    tcnt_d    = tcnt_q;
    if (state_d == CYC_IDLE)       tcnt_d = '0;
    else if (state_q == CYC_IDLE)  tcnt_d = TCNT_W'(1);
    else if (tcnt_q != '1)         tcnt_d = tcnt_q + TCNT_W'(1);
    mwr_cyc_d = mwr_cyc_q;
    if (mwr_early)   mwr_cyc_d = 1'b1;
    else if (mreq_b) mwr_cyc_d = 1'b0;
    done_d    = (state_q == CYC_IOWR) && (done_q || cap);
    err_d     = err_q | (!mreq_b & !iorq_b);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q   <= CYC_IDLE;
      tcnt_q    <= '0;
      arm_q     <= 1'b0;
      mreq_q    <= 1'b1;
      mwr_cyc_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      arm_q     <= arm_d;
      mreq_q    <= mreq_b;
      mwr_cyc_q <= mwr_cyc_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Falling-edge copies give the early predictor and the extended write flag.
  always_ff @(negedge clk or negedge reset_b) begin
    if (!reset_b) begin
      mreq_f_q      <= 1'b1;
      mwr_cyc_neg_q <= 1'b0;
    end else begin
      mreq_f_q      <= mreq_b;
      mwr_cyc_neg_q <= mwr_cyc_q;
    end
  end

  cpc_bankwr_hold u_hold (
    .clk        (clk),
    .reset_b    (reset_b),
    .cap_i      (cap),
    .cap_data_i (data),
    .ack_i      (bank_wr_ack),
    .vld_o      (bank_wr_vld),
    .data_o     (bank_wr_data),
    .ovf_o      (bank_wr_ovf)
  );

`ifdef WAIT_COUNT_EN
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  always_comb begin
    wcnt_d = wcnt_q;
    if (!ready && (state_q != CYC_IDLE) && (wcnt_q != '1)) wcnt_d = wcnt_q + WCNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) wcnt_q <= '0;
    else          wcnt_q <= wcnt_d;
  end

  assign wait_cnt = wcnt_q;
`else
  logic unused_ready;
  assign unused_ready = ready;
  assign wait_cnt     = '0;
`endif

  assign cyc_state   = state_q;
  assign tstate_cnt  = tcnt_q;
  assign mwr_cyc     = mwr_cyc_q;
  assign mwr_cyc_ext = mwr_cyc_q | mwr_cyc_neg_q;
  assign cyc_err     = err_q;

endmodule
